// File: rtl/shift_delay_line.sv
// shift_delay_line
//   Tapped register delay line of DEPTH stages, BW bits each. In shift mode
//   stage 0 loads i_d. In rotate mode stage 0 loads the last stage instead.
//   A fill counter records how many stages have been written since reset or
//   clear. The counter saturates at DEPTH and does not move on rotate edges.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst    : synchronous active-high reset (highest priority)
//   i_clr    : synchronous flush of stages and fill count
//   i_en     : advance the line one stage
//   i_mode   : 0 = shift in i_d, 1 = rotate last stage into stage 0
//   i_d      : serial data into stage 0
//   i_tap    : stage index driven onto o_q
//   o_q      : stage[i_tap], or 0 when i_tap >= DEPTH
//   o_q_last : stage[DEPTH-1]
//   o_cnt    : fill count
//   o_valid  : selected stage holds written data
//   o_full   : every stage holds written data
module shift_delay_line #(
    parameter int BW    = 8,
    parameter int DEPTH = 8,
    parameter int TW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_clr,
    input  logic          i_mode,
    input  logic [BW-1:0] i_d,
    input  logic [TW-1:0] i_tap,
    output logic [BW-1:0] o_q,
    output logic [BW-1:0] o_q_last,
    output logic [CW-1:0] o_cnt,
    output logic          o_valid,
    output logic          o_full
);

    logic [BW-1:0] stage_q [DEPTH];
    logic [BW-1:0] stage_d [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (i_clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_d[k] = '0;
            end
            cnt_d = '0;
        end else if (i_en) begin
            stage_d[0] = i_mode ? stage_q[DEPTH-1] : i_d;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            // Rotation only recirculates data already counted.
            if (!i_mode && (cnt_q != CW'(DEPTH))) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    // Taps beyond the last stage are only reachable when DEPTH is not a power of two.
    always_comb begin
        o_q = '0;
        if (int'(i_tap) < DEPTH) begin
            o_q = stage_q[i_tap];
        end
    end

    assign o_q_last = stage_q[DEPTH-1];
    assign o_cnt    = cnt_q;
    assign o_valid  = (int'(cnt_q) > int'(i_tap));
    assign o_full   = (cnt_q == CW'(DEPTH));

endmodule

// File: tb/tb_shift_delay_line.sv
module tb_shift_delay_line;

    localparam int BW    = 8;
    localparam int DEPTH = 8;
    localparam int TW    = 3;
    localparam int CW    = 4;

    logic          i_clk;
    logic          i_rst;
    logic          i_en;
    logic          i_clr;
    logic          i_mode;
    logic [BW-1:0] i_d;
    logic [TW-1:0] i_tap;
    logic [BW-1:0] o_q;
    logic [BW-1:0] o_q_last;
    logic [CW-1:0] o_cnt;
    logic          o_valid;
    logic          o_full;

    shift_delay_line #(.BW(BW), .DEPTH(DEPTH)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (i_en),
        .i_clr    (i_clr),
        .i_mode   (i_mode),
        .i_d      (i_d),
        .i_tap    (i_tap),
        .o_q      (o_q),
        .o_q_last (o_q_last),
        .o_cnt    (o_cnt),
        .o_valid  (o_valid),
        .o_full   (o_full)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int checks   = 0;
    int failures = 0;

    // Reference: the line as a queue, front = stage 0.
    int unsigned mdl[$];
    int          mcnt;

    typedef struct {
        logic          rst, clr, en, mode;
        logic [BW-1:0] d;
        logic [TW-1:0] tap;
        logic [BW-1:0] q, last;
        logic [CW-1:0] cnt;
        logic          valid, full;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mdl.delete();
        for (int k = 0; k < DEPTH; k++) mdl.push_back(0);
        mcnt = 0;
    endtask

    task automatic drive_edge(input logic rst, input logic clr, input logic en,
                              input logic mode, input logic [BW-1:0] d,
                              input logic [TW-1:0] tap);
        int unsigned t;
        i_rst = rst; i_clr = clr; i_en = en; i_mode = mode; i_d = d; i_tap = tap;
        @(posedge i_clk);
        if (rst || clr) begin
            model_reset();
        end else if (en) begin
            if (mode) begin
                t = mdl.pop_back();
                mdl.push_front(t);
            end else begin
                void'(mdl.pop_back());
                mdl.push_front(d);
                mcnt = (mcnt + 1 > DEPTH) ? DEPTH : mcnt + 1;
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        int eq;
        eq = (int'(i_tap) < DEPTH) ? int'(mdl[i_tap]) : 0;
        chk({tag, ".q"},     int'(o_q), eq);
        chk({tag, ".last"},  int'(o_q_last), int'(mdl[DEPTH-1]));
        chk({tag, ".cnt"},   int'(o_cnt), mcnt);
        chk({tag, ".valid"}, int'(o_valid), int'(mcnt > int'(i_tap)));
        chk({tag, ".full"},  int'(o_full), int'(mcnt == DEPTH));
    endtask

    // Stage k should hold 8-k (line loaded with 1..8).
    task automatic check_ramp(input string tag);
        for (int t = 0; t < DEPTH; t++) begin
            i_tap = TW'(t);
            #1;
            chk($sformatf("%s.stage%0d", tag, t), int'(o_q), DEPTH - t);
        end
        chk({tag, ".cnt"}, int'(o_cnt), DEPTH);
    endtask

    task automatic fill_ramp();
        drive_edge(0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= DEPTH; k++) drive_edge(0, 0, 1, 0, BW'(k), 0);
    endtask

    initial begin
        i_rst = 1'b1; i_clr = 1'b0; i_en = 1'b0; i_mode = 1'b0; i_d = '0; i_tap = '0;
        model_reset();

        // rst clr en mode d tap | q last cnt valid full
        vt[0] = '{1, 0, 1, 0, 8'hFF, 0, 8'h00, 8'h00, 4'd0, 0, 0};
        for (int k = 1; k <= 8; k++)
            vt[k] = '{0, 0, 1, 0, BW'(k), 0, BW'(k), (k == 8) ? 8'h01 : 8'h00,
                      CW'(k), 1, (k == 8)};
        vt[9]  = '{0, 0, 0, 0, 8'h77, 3, 8'h05, 8'h01, 4'd8, 1, 1};
        vt[10] = '{0, 0, 1, 1, 8'h99, 0, 8'h01, 8'h02, 4'd8, 1, 1};
        vt[11] = '{0, 1, 1, 0, 8'h55, 0, 8'h00, 8'h00, 4'd0, 0, 0};

        for (int i = 0; i < 12; i++) begin
            drive_edge(vt[i].rst, vt[i].clr, vt[i].en, vt[i].mode, vt[i].d, vt[i].tap);
            chk($sformatf("vec%0d.q", i),     int'(o_q),      int'(vt[i].q));
            chk($sformatf("vec%0d.last", i),  int'(o_q_last), int'(vt[i].last));
            chk($sformatf("vec%0d.cnt", i),   int'(o_cnt),    int'(vt[i].cnt));
            chk($sformatf("vec%0d.valid", i), int'(o_valid),  int'(vt[i].valid));
            chk($sformatf("vec%0d.full", i),  int'(o_full),   int'(vt[i].full));
        end

        // Latency through tap 2.
        drive_edge(0, 1, 0, 0, 0, 2);
        drive_edge(0, 0, 1, 0, 8'hA5, 2);
        chk("lat.e1.q", int'(o_q), 0);      chk("lat.e1.valid", int'(o_valid), 0);
        drive_edge(0, 0, 1, 0, 8'h00, 2);
        chk("lat.e2.q", int'(o_q), 0);      chk("lat.e2.valid", int'(o_valid), 0);
        drive_edge(0, 0, 1, 0, 8'h00, 2);
        chk("lat.e3.q", int'(o_q), 8'hA5);  chk("lat.e3.valid", int'(o_valid), 1);

        // Hold with i_d toggling.
        fill_ramp();
        for (int k = 0; k < 5; k++) drive_edge(0, 0, 0, k[0], (k[0]) ? 8'hFF : 8'h00, TW'(k));
        check_ramp("hold");

        // Rotate a full revolution.
        drive_edge(0, 0, 1, 1, 8'hEE, 0);
        chk("rot1.stage0", int'(o_q), 1);
        for (int k = 0; k < DEPTH - 1; k++) drive_edge(0, 0, 1, 1, 8'hEE, 0);
        check_ramp("rot8");

        // Reset between edges must not act until the edge.
        fill_ramp();
        i_en = 1'b0;
        i_rst = 1'b1;
        #2;
        chk("midrst.cnt", int'(o_cnt), 8);
        chk("midrst.last", int'(o_q_last), 1);
        i_rst = 1'b0;

        // Reset beats enable at fill count 4.
        drive_edge(0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) drive_edge(0, 0, 1, 0, BW'(8'h10 + k), 0);
        chk("rst4.pre.cnt", int'(o_cnt), 4);
        drive_edge(1, 0, 1, 0, 8'h3C, 0);
        chk("rst4.cnt", int'(o_cnt), 0);
        chk("rst4.q", int'(o_q), 0);

        // Saturation: 12 shift edges.
        drive_edge(0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 12; k++) drive_edge(0, 0, 1, 0, BW'(k), 0);
        chk("sat.cnt", int'(o_cnt), 8);
        chk("sat.last", int'(o_q_last), 5);
        chk("sat.q0", int'(o_q), 12);
        chk("sat.full", int'(o_full), 1);

        // Randomized against the queue model.
        for (int n = 0; n < 400; n++) begin
            drive_edge(($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                       BW'($urandom), TW'($urandom));
            check_model($sformatf("rnd%0d", n));
            i_tap = TW'($urandom);
            #1;
            check_model($sformatf("rnd%0d.tap", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
